bank_cmd_arbiter: RTL
=====================

// Module: bank_cmd_arbiter
// PURPOSE
//   Downstream of the NBANKS bank machines. Picks one command per cycle from their cmd streams
//   (ACT/PRE, READ, WRITE) and loads it into a registered single-slot output feeding the PHY command path.
//   Fair round-robin grant; enforces read/write turnaround (tWTR, tRTW) and ACT-to-ACT spacing (tRRD).
// PARAMETERS
//   NBANKS  8   number of bank machines (index = bank address)
//   AW      17  command address width (row / column+AP)
//   BAW     3   bank address width
// PORTS
//   sys_clk           in   1          sole clock, all logic on posedge
//   sys_rst_n         in   1          synchronous, active-low reset
//   bm_cmd_valid      in   NBANKS     per-bank command request
//   bm_cmd_ready      out  NBANKS     per-bank accept (one-hot or zero, combinational)
//   bm_cmd_a          in   NBANKS*AW  per-bank address, bank i at [i*AW +: AW]
//   bm_cmd_ba         in   NBANKS*BAW per-bank bank address
//   bm_cmd_cas/ras/we in   NBANKS     per-bank command bits
//   bm_cmd_is_cmd     in   NBANKS     ACT/PRE command
//   bm_cmd_is_read    in   NBANKS     read CAS
//   bm_cmd_is_write   in   NBANKS     write CAS
//   out_valid         out  1          output slot holds a command
//   out_ready         in   1          PHY accepts slot this cycle
//   out_a/out_ba      out  AW/BAW     registered address / bank
//   out_cas/ras/we    out  1          registered command bits
//   out_is_read/write out  1          registered CAS direction
//   tWTR_cfg/tRTW_cfg in   8          turnaround cycles write->read / read->write
//   tRRD_cfg          in   8          minimum cycles between ACT grants
// BEHAVIOUR
//   Reset (sys_rst_n=0 at posedge): out_valid=0, all out_* =0, state=RD, rr_ptr=0, all counters=0.
//     bm_cmd_ready is combinational and therefore 0 while out slot is full and out_ready=0.
//   Slot: load_en = ~out_valid | out_ready. Grant only when load_en; winner's fields registered, out_valid<=1.
//     If load_en and no winner, out_valid<=0. Latency bm handshake -> out_valid: 1 cycle.
//   ACT = ras & ~cas & ~we & is_cmd; PRE = is_cmd & ~ACT.
//   Eligibility of bank i (valid required):
//     PRE always; ACT iff rrd_cnt==0; is_read iff state==RD; is_write iff state==WR.
//   Arbiter: lowest eligible index at or after rr_ptr (wrapping). On grant g: rr_ptr<=(g+1) mod NBANKS.
//     bm_cmd_ready[g]=1 the same cycle only.
//   Direction FSM: RD, WR, RTW, WTR.
//     RD: if no valid is_read and >=1 valid is_write -> RTW, cnt<=tRTW_cfg.
//     WR: if no valid is_write and >=1 valid is_read -> WTR, cnt<=tWTR_cfg.
//     RTW/WTR: no CAS eligible; cnt-- each cycle; when cnt==0 -> WR/RD (cfg=0 gives one cycle in turnaround).
//     Switch decision is evaluated on the same cycle a CAS may be granted in the current direction.
//   tRRD: ACT granted -> rrd_cnt<=tRRD_cfg; else if rrd_cnt!=0, rrd_cnt--. cfg=0 means no blocking.
//   Simultaneous ACT grant and rrd_cnt reload: reload wins. Counters saturate at 0.
//   Reset mid-stream: slot discarded, no ready asserted that cycle.
// CONFIGURATION
//   BANK_CMD_ARB_STARVE_LIMIT_EN: adds 8-bit streak counter of consecutive same-direction CAS grants;
//     when it reaches 16 and an opposite-direction CAS is valid, leave RD/WR as if the current
//     direction were empty; counter clears on direction change.
//   Without the macro: direction changes only when the current direction has no valid request.
// STRUCTURE
//   mc_pkg: state enum (RD, WR, RTW, WTR), cmd field widths, ACT/PRE decode function, STARVE_LIMIT=16.
//   Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs grant one-hot, grant_idx.
//   Direction FSM, counters, and output slot remain in this module.
// TESTING
//   1. Single read on bank 5, out_ready=1 -> bm_cmd_ready[5] same cycle; out_valid/out_is_read next cycle; ba=5.
//   2. Banks 0,3,7 issue PRE continuously -> grants 0,3,7,0,3,7; rr_ptr wrap verified.
//   3. State RD, only bank 2 has write, tRTW_cfg=3 -> no CAS for 4 cycles; write granted on 5th.
//   4. ACT on bank 1 and bank 4, tRRD_cfg=4 -> second ACT granted exactly 5 cycles after the first.
//   5. out_ready=0 for 3 cycles, slot full -> bm_cmd_ready=0; out_* stable; drains on release.
//   6. (BANK_CMD_ARB_STARVE_LIMIT_EN) 20 reads plus 1 pending write -> read streak ends at 16, then RTW, then write.

Source files
------------

// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types, widths and decode helpers for the bank command arbiter.
package bank_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RD  = 2'd0,
    ST_WR  = 2'd1,
    ST_RTW = 2'd2,
    ST_WTR = 2'd3
  } dir_state_e;

  localparam int NBANKS_DEF   = 8;
  localparam int AW_DEF       = 17;
  localparam int BAW_DEF      = 3;
  localparam int CFG_W        = 8;
  localparam int STARVE_LIMIT = 16;

  function automatic logic cmd_is_act(input logic ras, input logic cas, input logic we,
                                      input logic is_cmd);
    return ras & ~cas & ~we & is_cmd;
  endfunction

endpackage

// File: rtl/bank_cmd_arbiter_if.sv
// Bank-machine command streams plus the registered PHY command slot.
interface bank_cmd_arbiter_if #(
  parameter int NBANKS = 8,
  parameter int AW     = 17,
  parameter int BAW    = 3
);
  logic [NBANKS-1:0]     bm_cmd_valid;
  logic [NBANKS-1:0]     bm_cmd_ready;
  logic [NBANKS*AW-1:0]  bm_cmd_a;
  logic [NBANKS*BAW-1:0] bm_cmd_ba;
  logic [NBANKS-1:0]     bm_cmd_cas;
  logic [NBANKS-1:0]     bm_cmd_ras;
  logic [NBANKS-1:0]     bm_cmd_we;
  logic [NBANKS-1:0]     bm_cmd_is_cmd;
  logic [NBANKS-1:0]     bm_cmd_is_read;
  logic [NBANKS-1:0]     bm_cmd_is_write;

  logic                  out_valid;
  logic                  out_ready;
  logic [AW-1:0]         out_a;
  logic [BAW-1:0]        out_ba;
  logic                  out_cas;
  logic                  out_ras;
  logic                  out_we;
  logic                  out_is_read;
  logic                  out_is_write;

  modport master (
    output bm_cmd_valid, bm_cmd_a, bm_cmd_ba, bm_cmd_cas, bm_cmd_ras, bm_cmd_we,
           bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write, out_ready,
    input  bm_cmd_ready, out_valid, out_a, out_ba, out_cas, out_ras, out_we,
           out_is_read, out_is_write
  );

  modport slave (
    input  bm_cmd_valid, bm_cmd_a, bm_cmd_ba, bm_cmd_cas, bm_cmd_ras, bm_cmd_we,
           bm_cmd_is_cmd, bm_cmd_is_read, bm_cmd_is_write, out_ready,
    output bm_cmd_ready, out_valid, out_a, out_ba, out_cas, out_ras, out_we,
           out_is_read, out_is_write
  );
endinterface

// File: rtl/bank_cmd_arbiter_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping.
module bank_cmd_arbiter_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  always_comb begin
    int            pos;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = IW'(pos);
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Picks one bank-machine command per cycle into a registered PHY slot with tRRD and R/W turnaround.
// Optional build macro BANK_CMD_ARB_STARVE_LIMIT_EN caps consecutive same-direction CAS grants.
//
// state  | meaning
// ST_RD  | reads eligible, writes wait
// ST_WR  | writes eligible, reads wait
// ST_RTW | read-to-write turnaround, no CAS eligible
// ST_WTR | write-to-read turnaround, no CAS eligible
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int NBANKS = NBANKS_DEF,
  parameter int AW     = AW_DEF,
  parameter int BAW    = BAW_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CFG_W-1:0] tWTR_cfg,
  input  logic [CFG_W-1:0] tRTW_cfg,
  input  logic [CFG_W-1:0] tRRD_cfg,
  bank_cmd_arbiter_if.slave bus
);
  localparam int IW = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  dir_state_e       state, state_nxt;
  logic [CFG_W-1:0] turn_cnt, turn_cnt_nxt, rrd_cnt, rrd_cnt_nxt;
  logic [IW-1:0]    rr_ptr, grant_idx;
  logic [NBANKS-1:0] is_act, elig, req, grant;
  logic             grant_vld, load_en, act_granted;
  logic             rd_pend, wr_pend, rd_open, wr_open, rd_starved, wr_starved;
  logic             leave_rd, leave_wr;

  logic [AW-1:0]    win_a, slot_a;
  logic [BAW-1:0]   win_ba, slot_ba;
  logic [4:0]       win_bits, slot_bits;
  logic             slot_valid;

  always_comb begin
    is_act = '0;
    for (int i = 0; i < NBANKS; i++) begin
      is_act[i] = cmd_is_act(bus.bm_cmd_ras[i], bus.bm_cmd_cas[i], bus.bm_cmd_we[i],
                             bus.bm_cmd_is_cmd[i]);
    end
  end

  assign rd_pend = |(bus.bm_cmd_valid & bus.bm_cmd_is_read);
  assign wr_pend = |(bus.bm_cmd_valid & bus.bm_cmd_is_write);
  assign rd_open = (state == ST_RD) & ~rd_starved;
  assign wr_open = (state == ST_WR) & ~wr_starved;

  assign elig = bus.bm_cmd_valid &
                ((bus.bm_cmd_is_cmd & (~is_act | {NBANKS{rrd_cnt == '0}})) |
                 (bus.bm_cmd_is_read & {NBANKS{rd_open}}) |
                 (bus.bm_cmd_is_write & {NBANKS{wr_open}}));

  // Gating with reset keeps ready low on a reset cycle even though the slot looks free.
  assign load_en = ~slot_valid | bus.out_ready;
  assign req     = elig & {NBANKS{load_en & sys_rst_n}};

  bank_cmd_arbiter_rr_arbiter #(.N(NBANKS), .IW(IW)) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign bus.bm_cmd_ready = grant;
  assign act_granted      = |(grant & is_act);

`ifdef BANK_CMD_ARB_STARVE_LIMIT_EN
  logic [7:0] streak;
  logic       cas_granted;
  assign cas_granted = |(grant & (bus.bm_cmd_is_read | bus.bm_cmd_is_write));
  // A saturated streak blocks the current direction so the opposite side gets the bus next.
  assign rd_starved  = (state == ST_RD) & (streak >= 8'(STARVE_LIMIT)) & wr_pend;
  assign wr_starved  = (state == ST_WR) & (streak >= 8'(STARVE_LIMIT)) & rd_pend;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)                           streak <= '0;
    else if (state_nxt != state)              streak <= '0;
    else if (cas_granted && streak != 8'hFF)  streak <= streak + 8'd1;
  end
`else
  assign rd_starved = 1'b0;
  assign wr_starved = 1'b0;
`endif

  assign leave_rd = wr_pend & (~rd_pend | rd_starved);
  assign leave_wr = rd_pend & (~wr_pend | wr_starved);

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    case (state)
      ST_RD:   if (leave_rd) begin state_nxt = ST_RTW; turn_cnt_nxt = tRTW_cfg; end
      ST_WR:   if (leave_wr) begin state_nxt = ST_WTR; turn_cnt_nxt = tWTR_cfg; end
      ST_RTW:  if (turn_cnt == '0) state_nxt = ST_WR; else turn_cnt_nxt = turn_cnt - 1'b1;
      ST_WTR:  if (turn_cnt == '0) state_nxt = ST_RD; else turn_cnt_nxt = turn_cnt - 1'b1;
      default: state_nxt = ST_RD;
    endcase

    rrd_cnt_nxt = rrd_cnt;
    if (act_granted)         rrd_cnt_nxt = tRRD_cfg;
    else if (rrd_cnt != '0)  rrd_cnt_nxt = rrd_cnt - 1'b1;
  end

  always_comb begin
    win_a    = '0;
    win_ba   = '0;
    win_bits = '0;
    for (int i = 0; i < NBANKS; i++) begin
      if (grant[i]) begin
        win_a    = bus.bm_cmd_a[i*AW +: AW];
        win_ba   = bus.bm_cmd_ba[i*BAW +: BAW];
        win_bits = {bus.bm_cmd_cas[i], bus.bm_cmd_ras[i], bus.bm_cmd_we[i],
                    bus.bm_cmd_is_read[i], bus.bm_cmd_is_write[i]};
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_RD;
      turn_cnt   <= '0;
      rrd_cnt    <= '0;
      rr_ptr     <= '0;
      slot_valid <= 1'b0;
      slot_a     <= '0;
      slot_ba    <= '0;
      slot_bits  <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      rrd_cnt  <= rrd_cnt_nxt;
      if (load_en) begin
        slot_valid <= grant_vld;
        if (grant_vld) begin
          slot_a    <= win_a;
          slot_ba   <= win_ba;
          slot_bits <= win_bits;
          rr_ptr    <= (grant_idx == IW'(NBANKS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid    = slot_valid;
  assign bus.out_a        = slot_a;
  assign bus.out_ba       = slot_ba;
  assign bus.out_cas      = slot_bits[4];
  assign bus.out_ras      = slot_bits[3];
  assign bus.out_we       = slot_bits[2];
  assign bus.out_is_read  = slot_bits[1];
  assign bus.out_is_write = slot_bits[0];

endmodule
